blk_thread_sched: RTL and testbench

Round-robin scheduler that decides which thread the md5 engine's block-creation stage works on next. It tracks per-thread readiness, picks one ready thread at a time, and issues a one-cycle start command with thread number and new-computation flag to the procb fetch / block-creation path. It then holds off until that path reports end of block. It sits between the thread-status logic (core completion, new-key loading) and the block-creation datapath, and serialises that datapath between up to N_THREADS threads.

---
 rtl/blk_thread_sched.sv | 170 +++++++++++++++++
 tb/tb_blk_thread_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_thread_sched.sv
// blk_thread_sched
// Round-robin scheduler for the md5 block-creation stage. It tracks which
// threads are ready for their next block, and picks one at a time starting
// from the round-robin pointer. It issues a one-cycle start with the thread
// number and new-computation flag, then waits for blk_end before it picks
// again. Protocol violations raise a sticky err flag.
module blk_thread_sched #(
   parameter int N_THREADS     = 16,
   parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
   parameter int WDOG_CYCLES   = 1023
) (
   input  logic                     CLK,
   input  logic                     rst_n,
   input  logic                     set_ready,
   input  logic [N_THREADS_MSB:0]   set_ready_num,
   input  logic                     set_new_comp,
   input  logic                     stall,
   input  logic                     blk_end,
   output logic                     start_en,
   output logic [N_THREADS_MSB:0]   start_thread_num,
   output logic                     start_new_comp,
   output logic                     busy,
   output logic [N_THREADS_MSB+1:0] n_ready,
   output logic                     err
);

   localparam int TW = N_THREADS_MSB + 1;           // thread number width
   localparam int CW = N_THREADS_MSB + 2;           // ready-count width
   localparam int WW = $clog2(WDOG_CYCLES + 1);     // watchdog width

   localparam logic [TW-1:0] LAST_THREAD = TW'(N_THREADS - 1);
   localparam logic [CW-1:0] THREAD_LIM  = CW'(N_THREADS);
   localparam logic [WW-1:0] WDOG_LAST   = WW'(WDOG_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_END
   } state_t;

   state_t               state;
   logic [N_THREADS-1:0] ready;
   logic [N_THREADS-1:0] new_comp;
   logic [TW-1:0]        rr;
   logic [WW-1:0]        wdog;

   logic [TW-1:0]        sel;
   logic                 sel_valid;
   logic                 issue;
   logic                 set_in_range;
   logic                 set_ok;
   logic                 set_err;
   logic [CW-1:0]        ready_cnt;

   // Classify an incoming set_ready as accepted or as a protocol error.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves
      // it unassigned and no latch is inferred.
      set_in_range = ({1'b0, set_ready_num} < THREAD_LIM);
      set_ok       = 1'b0;
      set_err      = 1'b0;
      if (set_ready) begin
         if (!set_in_range || ready[set_ready_num]) set_err = 1'b1;
         else                                       set_ok  = 1'b1;
      end
   end

   // Pick the first ready thread at or after rr, wrapping past the last thread.
   // The scan runs from the farthest offset to the nearest, so the nearest ready
   // thread is the last one written and wins.
   always_comb begin
      int j;
      sel       = '0;
      sel_valid = 1'b0;
      for (int i = N_THREADS - 1; i >= 0; i--) begin
         j = int'(rr) + i;
         if (j >= N_THREADS) j = j - N_THREADS;
         if (ready[j[TW-1:0]]) begin
            sel       = j[TW-1:0];
            sel_valid = 1'b1;
         end
      end
      issue = (state == S_IDLE) && sel_valid && !stall;
   end

   // Population count of the ready bits; n_ready registers it.
   always_comb begin
      ready_cnt = '0;
      for (int i = 0; i < N_THREADS; i++) begin
         ready_cnt = ready_cnt + CW'(ready[i[TW-1:0]]);
      end
   end

   // Per-thread ready/new_comp bits and the registered ready count.
   always_ff @(posedge CLK or negedge rst_n) begin
      // NOTE: the ready bits are ordinary flops, not a RAM. An asynchronous reset
      // must clear them so that no pending thread survives a reset.
      if (!rst_n) begin
         ready    <= '0;
         new_comp <= '0;
         n_ready  <= '0;
      end else begin
         if (set_ok) begin
            ready[set_ready_num]    <= 1'b1;
            new_comp[set_ready_num] <= set_new_comp;
         end
         // Issuing a thread clears its ready bit. This comes after the set path,
         // so the clear wins in the same cycle.
         if (issue) ready[sel] <= 1'b0;
         n_ready <= ready_cnt;
      end
   end

   // Scheduler FSM with registered start/busy outputs, watchdog and sticky error.
   always_ff @(posedge CLK or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments only. Every flop then
      // samples pre-edge values, whatever order the always blocks run in.
      if (!rst_n) begin
         state            <= S_IDLE;
         start_en         <= 1'b0;
         start_thread_num <= '0;
         start_new_comp   <= 1'b0;
         busy             <= 1'b0;
         rr               <= '0;
         wdog             <= '0;
         err              <= 1'b0;
      end else begin
         if (set_err) err <= 1'b1;
         case (state)
            S_IDLE: begin
               start_en <= 1'b0;
               if (blk_end) err <= 1'b1;
               if (issue) begin
                  start_thread_num <= sel;
                  start_new_comp   <= new_comp[sel];
                  rr               <= (sel == LAST_THREAD) ? '0 : sel + 1'b1;
                  start_en         <= 1'b1;
                  busy             <= 1'b1;
                  state            <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               start_en <= 1'b0;
               wdog     <= '0;
               if (blk_end) err <= 1'b1;
               state    <= S_WAIT_END;
            end
            S_WAIT_END: begin
               if (blk_end) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (wdog == WDOG_LAST) begin
                  // The block never ended. Flag it and give up; the thread is not re-readied.
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            default: begin
               start_en <= 1'b0;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_blk_thread_sched.sv
// Testbench for blk_thread_sched: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural scheduler model.
module tb_blk_thread_sched;

   localparam int N  = 16;
   localparam int WD = 8;

   logic       CLK          = 1'b0;
   logic       rst_n        = 1'b0;
   logic       set_ready    = 1'b0;
   logic [3:0] set_ready_num = '0;
   logic       set_new_comp = 1'b0;
   logic       stall        = 1'b0;
   logic       blk_end      = 1'b0;
   logic       start_en;
   logic [3:0] start_thread_num;
   logic       start_new_comp;
   logic       busy;
   logic [4:0] n_ready;
   logic       err;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   always #5 CLK = ~CLK;

   blk_thread_sched #(
      .N_THREADS     (N),
      .N_THREADS_MSB (3),
      .WDOG_CYCLES   (WD)
   ) dut (
      .CLK              (CLK),
      .rst_n            (rst_n),
      .set_ready        (set_ready),
      .set_ready_num    (set_ready_num),
      .set_new_comp     (set_new_comp),
      .stall            (stall),
      .blk_end          (blk_end),
      .start_en         (start_en),
      .start_thread_num (start_thread_num),
      .start_new_comp   (start_new_comp),
      .busy             (busy),
      .n_ready          (n_ready),
      .err              (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   bit m_ready [N];
   bit m_newc  [N];
   int m_rr;
   int m_phase;      // 0 = waiting to pick, 1 = start cycle, 2 = block running
   int m_wait;       // cycles spent waiting for blk_end
   bit e_start_en, e_newc, e_busy, e_err;
   int e_thread, e_nready;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_ready[i[3:0]] = 1'b0;
         m_newc[i[3:0]]  = 1'b0;
      end
      m_rr = 0; m_phase = 0; m_wait = 0;
      e_start_en = 1'b0; e_newc = 1'b0; e_busy = 1'b0; e_err = 1'b0;
      e_thread = 0; e_nready = 0;
   endtask

   task automatic model_step();
      int pc;
      int pick;
      pc = 0;
      for (int i = 0; i < N; i++) pc += int'(m_ready[i[3:0]]);
      pick = -1;
      if (m_phase == 0 && !stall) begin
         for (int k = 0; k < N; k++) begin
            if (pick < 0 && m_ready[4'((m_rr + k) % N)]) pick = (m_rr + k) % N;
         end
      end
      if (set_ready && m_ready[set_ready_num]) e_err = 1'b1;
      if (blk_end && m_phase != 2) e_err = 1'b1;
      e_start_en = 1'b0;
      case (m_phase)
         0: if (pick >= 0) begin
               e_thread   = pick;
               e_newc     = m_newc[4'(pick)];
               m_rr       = (pick + 1) % N;
               m_phase    = 1;
               e_start_en = 1'b1;
            end
         1: begin
               m_phase = 2;
               m_wait  = 0;
            end
         default: begin
               m_wait++;
               if (blk_end) m_phase = 0;
               else if (m_wait == WD) begin
                  e_err   = 1'b1;
                  m_phase = 0;
               end
            end
      endcase
      if (set_ready && !m_ready[set_ready_num]) begin
         m_ready[set_ready_num] = 1'b1;
         m_newc[set_ready_num]  = set_new_comp;
      end
      if (pick >= 0) m_ready[4'(pick)] = 1'b0;
      e_nready = pc;
      e_busy   = (m_phase != 0);
   endtask

   always @(posedge CLK or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   // Every cycle, compare all outputs against the model, away from the active edge.
   always @(negedge CLK) begin
      if (chk_en) begin
         check("m_start_en", 32'(start_en),         32'(e_start_en));
         check("m_thread",   32'(start_thread_num), 32'(e_thread));
         check("m_new_comp", 32'(start_new_comp),   32'(e_newc));
         check("m_busy",     32'(busy),             32'(e_busy));
         check("m_n_ready",  32'(n_ready),          32'(e_nready));
         check("m_err",      32'(err),              32'(e_err));
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic drive_ready(input int n, input bit nc);
      set_ready     = 1'b1;
      set_ready_num = 4'(n);
      set_new_comp  = nc;
      @(negedge CLK);
      set_ready     = 1'b0;
      set_new_comp  = 1'b0;
   endtask

   task automatic end_block();
      @(negedge CLK);
      blk_end = 1'b1;
      @(negedge CLK);
      blk_end = 1'b0;
   endtask

   task automatic wait_start(output int th, output int nt);
      nt = 0;
      do begin
         @(negedge CLK);
         nt++;
      end while (!start_en && nt < 20);
      check("start_seen", 32'(start_en), 32'd1);
      th = int'(start_thread_num);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #1 rst_n = 1'b0;
      set_ready = 1'b0; blk_end = 1'b0; stall = 1'b0;
      @(negedge CLK);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      int th, nt, k, cnt, n;
      int order2 [3];
      order2 = '{9, 0, 5};

      repeat (3) @(negedge CLK);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Reset values.
      check("rst_start_en", 32'(start_en), 32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_n_ready",  32'(n_ready),  32'd0);
      check("rst_err",      32'(err),      32'd0);

      // Thread 3 with new_comp: start two cycles after set_ready.
      drive_ready(3, 1'b1);
      check("t1_no_early_start", 32'(start_en), 32'd0);
      @(negedge CLK);
      check("t1_start_en", 32'(start_en),         32'd1);
      check("t1_thread",   32'(start_thread_num), 32'd3);
      check("t1_new_comp", 32'(start_new_comp),   32'd1);
      check("t1_busy",     32'(busy),             32'd1);
      end_block();
      check("t1_idle",     32'(busy),    32'd0);
      check("t1_n_ready",  32'(n_ready), 32'd0);

      // rr = 6 after issuing thread 5; then 0, 5, 9 ready -> order 9, 0, 5.
      drive_ready(5, 1'b0);
      wait_start(th, nt);
      check("t2_first", 32'(th), 32'd5);
      drive_ready(0, 1'b1);
      drive_ready(9, 1'b0);
      drive_ready(5, 1'b1);
      for (int i = 0; i < 3; i++) begin
         end_block();
         wait_start(th, nt);
         check("t2_order", 32'(th), 32'(order2[i]));
         check("t2_gap",   32'(nt + 1), 32'd2);
      end
      end_block();
      check("t2_err", 32'(err), 32'd0);

      // stall blocks issue while 4 threads wait.
      stall = 1'b1;
      drive_ready(1, 1'b0);
      drive_ready(2, 1'b1);
      drive_ready(3, 1'b0);
      drive_ready(4, 1'b1);
      repeat (4) begin
         @(negedge CLK);
         check("t3_stalled", 32'(start_en), 32'd0);
      end
      check("t3_n_ready", 32'(n_ready), 32'd4);
      stall = 1'b0;
      wait_start(th, nt);
      check("t3_first", 32'(th), 32'd1);
      for (int i = 2; i <= 4; i++) begin
         end_block();
         wait_start(th, nt);
         check("t3_order", 32'(th), 32'(i));
      end
      end_block();

      // Randomized traffic with no protocol violations.
      for (int i = 0; i < 2000; i++) begin
         blk_end       = (m_phase == 2) && ($urandom_range(0, 3) != 0);
         stall         = ($urandom_range(0, 7) == 0);
         n             = int'($urandom_range(0, N - 1));
         set_ready     = ($urandom_range(0, 2) == 0) && !m_ready[4'(n)];
         set_ready_num = 4'(n);
         set_new_comp  = 1'($urandom_range(0, 1));
         @(negedge CLK);
      end
      set_ready = 1'b0;
      stall     = 1'b0;
      for (int i = 0; i < 200; i++) begin
         blk_end = (m_phase == 2);
         @(negedge CLK);
      end
      blk_end = 1'b0;
      repeat (2) @(negedge CLK);
      check("rand_busy",    32'(busy),    32'd0);
      check("rand_n_ready", 32'(n_ready), 32'd0);
      check("rand_err",     32'(err),     32'd0);

      // Double set_ready for thread 2: err, bits unchanged, sticky.
      do_reset();
      stall = 1'b1;
      drive_ready(2, 1'b1);
      check("t4_err_clear", 32'(err), 32'd0);
      drive_ready(2, 1'b0);
      check("t4_err_set",  32'(err),     32'd1);
      check("t4_n_ready",  32'(n_ready), 32'd1);
      stall = 1'b0;
      wait_start(th, nt);
      check("t4_thread",      32'(th),             32'd2);
      check("t4_newc_kept",   32'(start_new_comp), 32'd1);
      end_block();
      repeat (5) @(negedge CLK);
      check("t4_err_sticky",  32'(err), 32'd1);

      // Watchdog: 8 waiting cycles without blk_end.
      do_reset();
      drive_ready(7, 1'b0);
      wait_start(th, nt);
      check("t5_thread", 32'(th), 32'd7);
      k = 0;
      do begin
         @(negedge CLK);
         k++;
         if (k == 8) check("t5_err_before", 32'(err), 32'd0);
      end while (busy && k < 30);
      check("t5_wdog_len", 32'(k),    32'd9);
      check("t5_err",      32'(err),  32'd1);
      check("t5_idle",     32'(busy), 32'd0);
      blk_end = 1'b1;
      @(negedge CLK);
      blk_end = 1'b0;
      @(negedge CLK);
      check("t5_err_spurious", 32'(err), 32'd1);

      // Reset in the middle of a block with 3 threads pending.
      do_reset();
      drive_ready(1, 1'b0);
      wait_start(th, nt);
      drive_ready(4, 1'b1);
      drive_ready(6, 1'b0);
      drive_ready(8, 1'b1);
      @(negedge CLK);
      check("t6_n_ready_pre", 32'(n_ready), 32'd3);
      check("t6_busy_pre",    32'(busy),    32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_start_en", 32'(start_en),         32'd0);
      check("t6_rst_thread",   32'(start_thread_num), 32'd0);
      check("t6_rst_newc",     32'(start_new_comp),   32'd0);
      check("t6_rst_busy",     32'(busy),             32'd0);
      check("t6_rst_n_ready",  32'(n_ready),          32'd0);
      check("t6_rst_err",      32'(err),              32'd0);
      @(negedge CLK);
      rst_n = 1'b1;
      cnt = 0;
      repeat (12) begin
         @(negedge CLK);
         if (start_en) cnt++;
      end
      check("t6_no_start", 32'(cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
